// File: rtl/rr_shared_reg_arbiter.sv
// Round-robin arbiter that serialises writes from NUM_REQ producers into one
// shared DATA_W-bit register, with capped hold bursts for the current owner.
module rr_shared_reg_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         hold_i,
  input  logic [NUM_REQ*DATA_W-1:0]  data_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [NUM_REQ-1:0]         ack_o,
  output logic [DATA_W-1:0]          q_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic                       valid_o
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_W   = $clog2(MAX_HOLD + 1);
  localparam bit HOLD_EN = (MAX_HOLD > 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_ack;
  logic [DATA_W-1:0]  r_q;
  logic [IDX_W-1:0]   r_owner;
  logic               r_valid;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_cur;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_found;
  logic [IDX_W-1:0]   w_win;
  logic [IDX_W:0]     w_cand;
  logic [IDX_W-1:0]   w_next_ptr;
  logic [NUM_REQ-1:0] w_win_oh;
  logic [NUM_REQ-1:0] w_cur_oh;
  logic [DATA_W-1:0]  w_cur_data;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_cur_req;
  logic               w_cur_hold;

  // Rotating priority search: first set request at or above r_ptr, wrapping to 0.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = {1'b0, r_ptr} + (IDX_W+1)'(i);
      if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!w_found && req_i[w_cand[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[IDX_W-1:0];
      end
    end
  end

  assign w_next_ptr = (w_win == IDX_W'(NUM_REQ-1)) ? '0 : w_win + IDX_W'(1);
  assign w_win_oh   = NUM_REQ'(1) << w_win;
  assign w_cur_oh   = NUM_REQ'(1) << r_cur;
  assign w_cur_data = data_i[int'(r_cur)*DATA_W +: DATA_W];
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_cur_req  = req_i[r_cur];
  assign w_cur_hold = hold_i[r_cur];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_q     <= '0;
      r_owner <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
      r_cur   <= '0;
      r_cnt   <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt   <= w_win_oh;
            r_cur   <= w_win;
            r_ptr   <= w_next_ptr;
            r_cnt   <= '0;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_cur_req) begin
            r_q     <= w_cur_data;
            r_ack   <= w_cur_oh;
            r_owner <= r_cur;
            r_valid <= 1'b1;
            r_cnt   <= CNT_W'(1);
            if (HOLD_EN && w_cur_hold) begin
              r_state <= S_HOLD;
            end else begin
              r_gnt   <= '0;
              r_state <= S_IDLE;
            end
          end else begin
            r_gnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (w_cur_req) begin
            r_q     <= w_cur_data;
            r_ack   <= w_cur_oh;
            r_owner <= r_cur;
            r_valid <= 1'b1;
            r_cnt   <= w_cnt_inc;
          end
          // Stay only while the owner keeps both lines up and the cap is not reached.
          if (!(w_cur_req && w_cur_hold && (w_cnt_inc != CNT_W'(MAX_HOLD)))) begin
            r_gnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt_o   = r_gnt;
  assign ack_o   = r_ack;
  assign q_o     = r_q;
  assign owner_o = r_owner;
  assign valid_o = r_valid;

endmodule

// File: tb/tb_rr_shared_reg_arbiter.sv
// Directed bench for rr_shared_reg_arbiter: a vector table for the 4-requester
// instance plus hand sequences for async reset, hold release and a 3-requester no-hold instance.
module tb_rr_shared_reg_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a;
  logic [3:0]  req_a, hold_a, gnt_a, ack_a;
  logic [31:0] data_a;
  logic [7:0]  q_a;
  logic [1:0]  own_a;
  logic        vld_a;

  logic        rst_b;
  logic [2:0]  req_b, hold_b, gnt_b, ack_b;
  logic [23:0] data_b;
  logic [7:0]  q_b;
  logic [1:0]  own_b;
  logic        vld_b;

  rr_shared_reg_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_HOLD(4)) dut_a (
    .clk(clk), .reset(rst_a), .req_i(req_a), .hold_i(hold_a), .data_i(data_a),
    .gnt_o(gnt_a), .ack_o(ack_a), .q_o(q_a), .owner_o(own_a), .valid_o(vld_a)
  );

  rr_shared_reg_arbiter #(.NUM_REQ(3), .DATA_W(8), .MAX_HOLD(1)) dut_b (
    .clk(clk), .reset(rst_b), .req_i(req_b), .hold_i(hold_b), .data_i(data_b),
    .gnt_o(gnt_b), .ack_o(ack_b), .q_o(q_b), .owner_o(own_b), .valid_o(vld_b)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  hold;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic [1:0]  own;
    logic        vld;
  } vec_t;

  vec_t tbl[$];
  int checks   = 0;
  int failures = 0;

  task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] hold,
                     input logic [31:0] data, input logic [3:0] gnt, input logic [3:0] ack,
                     input logic [7:0] q, input logic [1:0] own, input logic vld);
    vec_t v;
    v.rst = rst; v.req = req; v.hold = hold; v.data = data;
    v.gnt = gnt; v.ack = ack; v.q = q; v.own = own; v.vld = vld;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_a(input string tag, input logic [3:0] g, input logic [3:0] a,
                         input logic [7:0] q, input logic [1:0] o, input logic v);
    check({tag, ".gnt"},   32'(gnt_a), 32'(g));
    check({tag, ".ack"},   32'(ack_a), 32'(a));
    check({tag, ".q"},     32'(q_a),   32'(q));
    check({tag, ".owner"}, 32'(own_a), 32'(o));
    check({tag, ".valid"}, 32'(vld_a), 32'(v));
  endtask

  localparam logic [31:0] D2 = 32'h13121110;

  initial begin
    rst_a = 1'b0; req_a = '0; hold_a = '0; data_a = '0;
    rst_b = 1'b0; req_b = '0; hold_b = '0; data_b = '0;

    // reset, single request
    add(0, 4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 8'h00, 2'd0, 0);
    add(1, 4'b0100, 4'b0000, 32'h00A50000, 4'b0100, 4'b0000, 8'h00, 2'd0, 0);
    add(1, 4'b0100, 4'b0000, 32'h00A50000, 4'b0000, 4'b0100, 8'hA5, 2'd2, 1);
    add(1, 4'b0000, 4'b0000, 32'h00A50000, 4'b0000, 4'b0000, 8'hA5, 2'd2, 1);
    add(0, 4'b0000, 4'b0000, 32'h0,        4'b0000, 4'b0000, 8'h00, 2'd0, 0);
    // fairness sweep with arbitration bubbles
    add(1, 4'b1111, 4'b0000, D2, 4'b0001, 4'b0000, 8'h00, 2'd0, 0);
    add(1, 4'b1111, 4'b0000, D2, 4'b0000, 4'b0001, 8'h10, 2'd0, 1);
    add(1, 4'b1111, 4'b0000, D2, 4'b0010, 4'b0000, 8'h10, 2'd0, 1);
    add(1, 4'b1111, 4'b0000, D2, 4'b0000, 4'b0010, 8'h11, 2'd1, 1);
    add(1, 4'b1111, 4'b0000, D2, 4'b0100, 4'b0000, 8'h11, 2'd1, 1);
    add(1, 4'b1111, 4'b0000, D2, 4'b0000, 4'b0100, 8'h12, 2'd2, 1);
    add(1, 4'b1111, 4'b0000, D2, 4'b1000, 4'b0000, 8'h12, 2'd2, 1);
    add(1, 4'b1111, 4'b0000, D2, 4'b0000, 4'b1000, 8'h13, 2'd3, 1);
    add(1, 4'b1111, 4'b0000, D2, 4'b0001, 4'b0000, 8'h13, 2'd3, 1);
    add(1, 4'b1111, 4'b0000, D2, 4'b0000, 4'b0001, 8'h10, 2'd0, 1);
    add(1, 4'b0000, 4'b0000, D2, 4'b0000, 4'b0000, 8'h10, 2'd0, 1);
    add(0, 4'b0000, 4'b0000, 32'h0, 4'b0000, 4'b0000, 8'h00, 2'd0, 0);
    // burst capped at 4 writes, then requester 1 wins
    add(1, 4'b0011, 4'b0001, 32'h00007700, 4'b0001, 4'b0000, 8'h00, 2'd0, 0);
    add(1, 4'b0011, 4'b0001, 32'h00007701, 4'b0001, 4'b0001, 8'h01, 2'd0, 1);
    add(1, 4'b0011, 4'b0001, 32'h00007702, 4'b0001, 4'b0001, 8'h02, 2'd0, 1);
    add(1, 4'b0011, 4'b0001, 32'h00007703, 4'b0001, 4'b0001, 8'h03, 2'd0, 1);
    add(1, 4'b0011, 4'b0001, 32'h00007704, 4'b0000, 4'b0001, 8'h04, 2'd0, 1);
    add(1, 4'b0011, 4'b0001, 32'h00007705, 4'b0010, 4'b0000, 8'h04, 2'd0, 1);
    add(1, 4'b0011, 4'b0000, 32'h00007705, 4'b0000, 4'b0010, 8'h77, 2'd1, 1);
    // abort by requester 3, pointer wraps to 0
    add(1, 4'b1000, 4'b0000, 32'hEE007742, 4'b1000, 4'b0000, 8'h77, 2'd1, 1);
    add(1, 4'b0011, 4'b0000, 32'hEE007742, 4'b0000, 4'b0000, 8'h77, 2'd1, 1);
    add(1, 4'b0011, 4'b0000, 32'hEE007742, 4'b0001, 4'b0000, 8'h77, 2'd1, 1);
    add(1, 4'b0011, 4'b0000, 32'hEE007742, 4'b0000, 4'b0001, 8'h42, 2'd0, 1);

    #1;
    foreach (tbl[i]) begin
      rst_a  = tbl[i].rst;
      req_a  = tbl[i].req;
      hold_a = tbl[i].hold;
      data_a = tbl[i].data;
      @(posedge clk); #1;
      check_a($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].ack, tbl[i].q, tbl[i].own, tbl[i].vld);
    end

    // async reset in the middle of a burst
    rst_a = 1'b0; req_a = '0; hold_a = '0;
    @(posedge clk); #1;
    rst_a = 1'b1; req_a = 4'b0001; hold_a = 4'b0001; data_a = 32'h0000005A;
    @(posedge clk); #1;
    check_a("burst_grant", 4'b0001, 4'b0000, 8'h00, 2'd0, 1'b0);
    @(posedge clk); #1;
    check_a("burst_write", 4'b0001, 4'b0001, 8'h5A, 2'd0, 1'b1);
    #2 rst_a = 1'b0;
    #1;
    check_a("async_rst", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
    rst_a = 1'b1; req_a = 4'b0011; hold_a = 4'b0001; data_a = 32'h00000061;
    @(posedge clk); #1;
    check_a("post_rst_grant", 4'b0001, 4'b0000, 8'h00, 2'd0, 1'b0);
    @(posedge clk); #1;
    check_a("hold_write1", 4'b0001, 4'b0001, 8'h61, 2'd0, 1'b1);
    hold_a = 4'b0000; data_a = 32'h00000066;
    @(posedge clk); #1;
    check_a("hold_final", 4'b0000, 4'b0001, 8'h66, 2'd0, 1'b1);
    @(posedge clk); #1;
    check_a("next_after_hold", 4'b0010, 4'b0000, 8'h66, 2'd0, 1'b1);

    // 3-requester instance without hold capability
    begin
      logic [2:0] exp_g [8] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
      logic [2:0] exp_k [8] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
      logic [7:0] exp_q [8] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h01};
      rst_b = 1'b1; req_b = 3'b111; hold_b = 3'b111; data_b = 24'h030201;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        check($sformatf("b%0d.gnt", i), 32'(gnt_b), 32'(exp_g[i]));
        check($sformatf("b%0d.ack", i), 32'(ack_b), 32'(exp_k[i]));
        check($sformatf("b%0d.q", i),   32'(q_b),   32'(exp_q[i]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
